// File: rtl/sram128x48_pkg.sv
// Shared constants and types for the 128x48 SRAM request controller.
package sram128x48_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 48;
    localparam int unsigned BYTES  = 6;
    localparam int unsigned WORDS  = 128;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Registered pin bundle presented to the macro.
    typedef struct packed {
        logic              csb;
        logic              web;
        logic [ADDR_W-1:0] a;
        logic [BYTES-1:0]  wbm;
        logic [DATA_W-1:0] i;
    } mem_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Circular response buffer; head is combinational from the storage array.
module sram_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    // Pops against an empty buffer are dropped; pushes never meet a full one.
    assign pop_ok = pop_i && (count_q != '0);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage; contents are only meaningful where count covers them.
    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = data_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram128x48_req_ctrl.sv
// Request-side controller for the 128x48 single-port SRAM macro.
module sram128x48_req_ctrl
    import sram128x48_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 4,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BYTES-1:0]  req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_csb,
    output logic              mem_web,
    output logic              mem_oeb,
    output logic [BYTES-1:0]  mem_wbm,
    output logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] mem_o
);
    localparam int unsigned CNT_W     = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned SUM_W     = CNT_W + 1;
    localparam state_e      RST_STATE = INIT_ZERO ? INIT : RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    mem_req_t          mem_q, mem_d;
    logic              rd_s1_q, rd_s1_d;
    logic              rd_s2_q, rd_s2_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  occupancy;
    logic              accept;

    // Reserve a FIFO slot for every read still travelling through the macro.
    assign occupancy  = SUM_W'(fifo_count) + SUM_W'(rd_s1_q) + SUM_W'(rd_s2_q);
    assign req_ready  = (state_q == RUN) && (occupancy < SUM_W'(RESP_DEPTH));
    assign accept     = req_valid && req_ready;
    assign init_done  = (state_q == RUN);
    assign resp_valid = (fifo_count != '0);

    assign mem_csb = mem_q.csb;
    assign mem_web = mem_q.web;
    assign mem_a   = mem_q.a;
    assign mem_wbm = mem_q.wbm;
    assign mem_i   = mem_q.i;
    assign mem_oeb = 1'b0;

    // Next-state: zero-fill sweep in INIT, request forwarding in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_d       = mem_q;
        mem_d.csb   = 1'b1;
        mem_d.web   = 1'b1;
        mem_d.wbm   = '0;
        rd_s1_d     = 1'b0;
        rd_s2_d     = rd_s1_q;
        case (state_q)
            INIT: begin
                mem_d.csb = 1'b0;
                mem_d.web = 1'b0;
                mem_d.a   = cnt_q;
                mem_d.wbm = '1;
                mem_d.i   = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    mem_d.csb = 1'b0;
                    mem_d.web = ~req_we;
                    mem_d.a   = req_addr;
                    mem_d.i   = req_wdata;
                    mem_d.wbm = req_we ? req_wmask : '0;
                    rd_s1_d   = ~req_we;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, sweep counter, macro pin registers and read pipeline flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            mem_q   <= '{csb: 1'b1, web: 1'b1, a: '0, wbm: '0, i: '0};
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            rd_s1_q <= rd_s1_d;
            rd_s2_q <= rd_s2_d;
        end
    end

    // Macro output is valid two edges after accept; capture it then.
    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (rd_s2_q),
        .push_data_i (mem_o),
        .pop_i       (resp_ready),
        .count_o     (fifo_count),
        .head_o      (resp_data)
    );

endmodule
